// File: rtl/nn_unpooling_if.sv
// Stream bundle for the 2x2 unpooling block: pooled input stream plus upsampled output stream.
interface nn_unpooling_if #(
    parameter int DATA_W = 6
) ();
    logic [DATA_W-1:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;
    logic              row;

    modport master (
        output data_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  data_out,
        input  out_valid,
        input  row
    );

    modport slave (
        input  data_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output data_out,
        output out_valid,
        output row
    );
endinterface

// File: rtl/nn_unpooling.sv
// 2x2 nearest-neighbour unpooling: each pooled value is emitted twice per row and each row twice.
// Optional macro UNPOOL_ZERO_FILL_EN selects max-unpool zero fill and removes the line buffer.
module nn_unpooling #(
    parameter int DATA_W  = 6,
    parameter int IN_W    = 8,
    parameter int ROWS_IN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fire_i,
    output logic           done_o,
    nn_unpooling_if.slave  bus
);

    localparam int CIW = $clog2(IN_W + 1);
    localparam int COW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW  = (ROWS_IN > 1) ? $clog2(ROWS_IN) : 1;

    localparam logic [CIW-1:0] COL_IN_MAX = CIW'(IN_W);
    localparam logic [COW-1:0] COL_LAST   = COW'(IN_W - 1);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS_IN - 1);

`ifdef UNPOOL_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROW_A = 2'd1,
        ROW_B = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CIW-1:0]    col_in_q, col_in_d;
    logic [COW-1:0]    col_out_q, col_out_d;
    logic [RW-1:0]     rows_q, rows_d;
    logic              copy_q, copy_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              row_q, row_d;
    logic              done_q, done_d;

    logic              in_ready_s;
    logic              accept_s;
    logic              hs_s;
    logic [DATA_W-1:0] lb_cur_s;
    logic [DATA_W-1:0] lb_nxt_s;

    // in_ready opens only when the last copy of the current value is leaving (or nothing is shown)
    assign in_ready_s = (state_q == ROW_A) && (col_in_q < COL_IN_MAX) &&
                        (!out_valid_q || (bus.out_ready && copy_q));
    assign accept_s   = in_ready_s & bus.in_valid;
    assign hs_s       = out_valid_q & bus.out_ready;

`ifdef UNPOOL_ZERO_FILL_EN
    assign lb_cur_s = {DATA_W{1'b0}};
    assign lb_nxt_s = {DATA_W{1'b0}};
`else
    logic [DATA_W-1:0] linebuf [IN_W];

    // Line buffer capture of the live row; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!rst && accept_s) begin
            linebuf[col_in_q[COW-1:0]] <= bus.data_in;
        end
    end

    assign lb_cur_s = linebuf[col_out_q];
    assign lb_nxt_s = linebuf[col_out_q + COW'(1)];
`endif

    // Next-state and datapath control for the row-pair sequencer
    always_comb begin
        state_d     = state_q;
        col_in_d    = col_in_q;
        col_out_d   = col_out_q;
        rows_d      = rows_q;
        copy_d      = copy_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        row_d       = row_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire_i) begin
                    state_d   = ROW_A;
                    col_in_d  = {CIW{1'b0}};
                    col_out_d = {COW{1'b0}};
                    rows_d    = {RW{1'b0}};
                    copy_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            ROW_A: begin
                if (accept_s) begin
                    data_out_d  = bus.data_in;
                    out_valid_d = 1'b1;
                    copy_d      = 1'b0;
                    row_d       = 1'b0;
                    col_in_d    = col_in_q + CIW'(1);
                end else if (hs_s && !copy_q) begin
                    copy_d     = 1'b1;
                    data_out_d = ZERO_FILL ? {DATA_W{1'b0}} : data_out_q;
                end else if (hs_s && copy_q) begin
                    out_valid_d = 1'b0;
                    if (col_in_q == COL_IN_MAX) begin
                        state_d  = ROW_B;
                        col_in_d = {CIW{1'b0}};
                        copy_d   = 1'b0;
                    end else begin
                        state_d = ROW_A;
                    end
                end else begin
                    state_d = ROW_A;
                end
            end

            ROW_B: begin
                if (!out_valid_q) begin
                    data_out_d  = lb_cur_s;
                    out_valid_d = 1'b1;
                    copy_d      = 1'b0;
                    row_d       = 1'b1;
                end else if (hs_s && !copy_q) begin
                    copy_d = 1'b1;
                end else if (hs_s && copy_q) begin
                    if (col_out_q == COL_LAST) begin
                        out_valid_d = 1'b0;
                        col_out_d   = {COW{1'b0}};
                        copy_d      = 1'b0;
                        if (rows_q < ROW_LAST) begin
                            state_d = ROW_A;
                            rows_d  = rows_q + RW'(1);
                        end else begin
                            state_d = FIN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        col_out_d  = col_out_q + COW'(1);
                        data_out_d = lb_nxt_s;
                        copy_d     = 1'b0;
                    end
                end else begin
                    state_d = ROW_B;
                end
            end

            FIN: begin
                state_d = IDLE;
                rows_d  = {RW{1'b0}};
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_in_q    <= {CIW{1'b0}};
            col_out_q   <= {COW{1'b0}};
            rows_q      <= {RW{1'b0}};
            copy_q      <= 1'b0;
            data_out_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            row_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_in_q    <= col_in_d;
            col_out_q   <= col_out_d;
            rows_q      <= rows_d;
            copy_q      <= copy_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            row_q       <= row_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.row       = row_q;
    assign done_o        = done_q;

endmodule
